// File: rtl/ffs_frame_buffer.sv
// First-word-fall-through AXI-Stream frame buffer with live occupancy (FFSTail) for the TX gate.
// Define FFS_FRAME_COUNT_EN for store-and-forward egress gated on complete stored frames.
module ffs_frame_buffer #(
   parameter int unsigned MAX_INTERNAL_SPACE = 64,
   parameter int unsigned DATA_WIDTH         = 32
) (
   input  logic                                  ACLK,
   input  logic                                  ARESETN,
   input  logic [DATA_WIDTH-1:0]                 S_AXIS_tdata,
   input  logic                                  S_AXIS_tlast,
   input  logic                                  S_AXIS_tvalid,
   output logic                                  S_AXIS_tready,
   output logic [DATA_WIDTH-1:0]                 M_AXIS_tdata,
   output logic                                  M_AXIS_tlast,
   output logic                                  M_AXIS_tvalid,
   input  logic                                  M_AXIS_tready,
   output logic [$clog2(MAX_INTERNAL_SPACE):0]   FFSTail,
   output logic [$clog2(MAX_INTERNAL_SPACE):0]   FrameCount
);

   localparam int unsigned AW = $clog2(MAX_INTERNAL_SPACE);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = DATA_WIDTH + 1;

   logic [EW-1:0] mem [MAX_INTERNAL_SPACE];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          tready_q;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;

   assign push = S_AXIS_tvalid & tready_q;
   assign pop  = M_AXIS_tvalid & M_AXIS_tready;

   // Occupancy update: simultaneous push and pop cancel out.
   always_comb begin
      count_next = count;
      unique case ({push, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Pointers, occupancy and ingress ready; ready looks at next occupancy so full costs no bubble.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         tready_q <= 1'b0;
      end else begin
         if (push) wp <= wp + AW'(1);
         if (pop)  rp <= rp + AW'(1);
         count    <= count_next;
         tready_q <= (count_next < CW'(MAX_INTERNAL_SPACE));
      end
   end

   // Storage is deliberately left out of reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge ACLK) begin
      if (push) mem[wp] <= {S_AXIS_tlast, S_AXIS_tdata};
   end

   assign head          = mem[rp];
   assign M_AXIS_tdata  = head[DATA_WIDTH-1:0];
   assign M_AXIS_tlast  = head[DATA_WIDTH];
   assign S_AXIS_tready = tready_q;
   assign FFSTail       = count;

`ifdef FFS_FRAME_COUNT_EN
   logic [CW-1:0] frames;
   logic [CW-1:0] frames_next;
   logic          frame_in;
   logic          frame_out;

   assign frame_in  = push & S_AXIS_tlast;
   assign frame_out = pop & M_AXIS_tlast;

   always_comb begin
      frames_next = frames;
      unique case ({frame_in, frame_out})
         2'b10:   frames_next = frames + CW'(1);
         2'b01:   frames_next = frames - CW'(1);
         default: frames_next = frames;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) frames <= '0;
      else          frames <= frames_next;
   end

   // Egress held until at least one whole frame is buffered.
   assign M_AXIS_tvalid = (frames != '0);
   assign FrameCount    = frames;
`else
   assign M_AXIS_tvalid = (count != '0);
   assign FrameCount    = '0;
`endif

endmodule

// File: tb/tb_ffs_frame_buffer.sv
// Scoreboard bench for ffs_frame_buffer: accepted beats are queued, a monitor checks egress order,
// and a per-cycle checker compares tready/tvalid/FFSTail/FrameCount against the queue contents.
module tb_ffs_frame_buffer;

   localparam int unsigned D  = 64;
   localparam int unsigned W  = 32;
   localparam int unsigned CW = $clog2(D) + 1;

   logic          aclk;
   logic          aresetn;
   logic [W-1:0]  s_tdata;
   logic          s_tlast;
   logic          s_tvalid;
   logic          s_tready;
   logic [W-1:0]  m_tdata;
   logic          m_tlast;
   logic          m_tvalid;
   logic          m_tready;
   logic [CW-1:0] ffs_tail;
   logic [CW-1:0] frame_count;

   logic [W:0] exp_q[$];
   int         checks;
   int         errors;
   logic       rst_at_edge;
   int         exp_frames;
   logic       exp_valid;
   logic       rand_done;

   ffs_frame_buffer #(.MAX_INTERNAL_SPACE(D), .DATA_WIDTH(W)) dut (
      .ACLK(aclk), .ARESETN(aresetn),
      .S_AXIS_tdata(s_tdata), .S_AXIS_tlast(s_tlast), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
      .M_AXIS_tdata(m_tdata), .M_AXIS_tlast(m_tlast), .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready),
      .FFSTail(ffs_tail), .FrameCount(frame_count)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // Egress monitor: every pop handshake must match the oldest accepted beat.
   initial forever begin
      @(negedge aclk);
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
         if (exp_q.size() == 0) fail_now("pop_on_empty");
         else chk("egress_beat", 64'({m_tlast, m_tdata}), 64'(exp_q.pop_front()));
      end
   end

   // Per-cycle status checker, sampled just after each rising edge.
   initial forever begin
      @(posedge aclk);
      rst_at_edge = aresetn;
      #2;
      if (rst_at_edge !== 1'b1) begin
         exp_q.delete();
         chk("rst_tready", 64'(s_tready), 64'(0));
         chk("rst_tvalid", 64'(m_tvalid), 64'(0));
         chk("rst_ffstail", 64'(ffs_tail), 64'(0));
         chk("rst_framecount", 64'(frame_count), 64'(0));
      end else begin
         exp_frames = 0;
         foreach (exp_q[k]) if (exp_q[k][W]) exp_frames++;
`ifdef FFS_FRAME_COUNT_EN
         exp_valid = (exp_frames != 0);
`else
         exp_valid = (exp_q.size() != 0);
         exp_frames = 0;
`endif
         chk("tready", 64'(s_tready), 64'(exp_q.size() < D));
         chk("tvalid", 64'(m_tvalid), 64'(exp_valid));
         chk("ffstail", 64'(ffs_tail), 64'(exp_q.size()));
         chk("framecount", 64'(frame_count), 64'(exp_frames));
      end
   end

   // Present one beat and hold until accepted; leaves tvalid high on return (posedge+1).
   task automatic send_beat(input logic [W-1:0] data, input logic last);
      logic ok;
      ok = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = data;
      s_tlast  = last;
      for (int k = 0; k < 300; k++) begin
         @(negedge aclk);
         if (s_tready === 1'b1) begin
            exp_q.push_back({last, data});
            ok = 1'b1;
         end
         @(posedge aclk);
         #1;
         if (ok) break;
      end
      if (!ok) fail_now("send_beat");
   endtask

   task automatic wait_empty(input string name);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 500; k++) begin
         @(posedge aclk);
         #3;
         if (exp_q.size() == 0 && ffs_tail == '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now(name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      rand_done = 1'b0;
      aresetn   = 1'b0;
      s_tvalid  = 1'b0;
      s_tdata   = '0;
      s_tlast   = 1'b0;
      m_tready  = 1'b0;

      // Reset then idle
      repeat (4) @(posedge aclk);
      #1;
      chk("tready_in_reset", 64'(s_tready), 64'(0));
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      chk("tready_after_reset", 64'(s_tready), 64'(1));
      chk("idle_ffstail", 64'(ffs_tail), 64'(0));
      chk("idle_tvalid", 64'(m_tvalid), 64'(0));

      // Fill to full with egress stalled
      for (int i = 0; i < 64; i++) send_beat(W'(i), i == 63);
      chk("full_ffstail", 64'(ffs_tail), 64'(64));
      chk("full_tready", 64'(s_tready), 64'(0));
      s_tdata = 32'hAA;
      s_tlast = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         chk("beat65_blocked", 64'(s_tready), 64'(0));
         @(posedge aclk);
         #1;
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      @(posedge aclk);
      #1;
      m_tready = 1'b0;
      chk("pop_at_full_tready", 64'(s_tready), 64'(1));
      chk("pop_at_full_ffstail", 64'(ffs_tail), 64'(63));
      m_tready = 1'b1;
      wait_empty("drain_full");

      // Full-rate streaming across pointer wrap
      for (int i = 0; i < 200; i++) send_beat(32'h1000 + W'(i), (i % 8) == 7);
      s_tvalid = 1'b0;
      wait_empty("drain_stream");

      // Random handshakes on both sides
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(0, 1) == 0) begin
                  s_tvalid = 1'b0;
                  @(posedge aclk);
                  #1;
               end
               send_beat(W'(i * 3 + 7), ((i % 7) == 6) || (i == 999));
            end
            s_tvalid  = 1'b0;
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge aclk);
               #1;
               m_tready = ($urandom_range(0, 1) == 1);
            end
         end
      join
      m_tready = 1'b1;
      wait_empty("drain_random");

      // Single 5-beat frame: gating behaviour differs by mode
      for (int i = 0; i < 5; i++) begin
         send_beat(32'h500 + W'(i), i == 4);
`ifdef FFS_FRAME_COUNT_EN
         chk("frame_gate_tvalid", 64'(m_tvalid), 64'(i == 4));
`else
         chk("cut_through_tvalid", 64'(m_tvalid), 64'(1));
`endif
      end
      s_tvalid = 1'b0;
      wait_empty("drain_frame");
      chk("frame_count_zero", 64'(frame_count), 64'(0));

      // Reset in the middle of a frame discards the partial frame
      m_tready = 1'b0;
      for (int i = 0; i < 3; i++) send_beat(32'h600 + W'(i), 1'b0);
      s_tvalid = 1'b0;
      aresetn  = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      chk("midreset_ffstail", 64'(ffs_tail), 64'(0));
      chk("midreset_tvalid", 64'(m_tvalid), 64'(0));
      m_tready = 1'b1;
      for (int i = 0; i < 4; i++) send_beat(32'h700 + W'(i), i == 3);
      s_tvalid = 1'b0;
      wait_empty("drain_after_reset");

      repeat (2) @(posedge aclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
